seq_detector_sr: RTL and testbench

- Serial pattern detector that consumes the registered single-bit stream produced by the team's D flip-flop stage (its q drives din).
- Holds a sliding window of the last N qualified bits.
- Raises a registered one-cycle match pulse when the window equals PATTERN.
- Keeps a saturating count of matches.
- Supports overlapping and non-overlapping detection, plus a synchronous flush so upstream clear events can be mirrored.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detector_sr.sv | 76 +++++++
 tb/tb_seq_detector_sr.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and helpers for the serial pattern detector
// Contents:
//   SEQ_N, SEQ_PATTERN, SEQ_CNT_W : default pattern length, pattern and counter width
//   fill_width(n)                 : bits needed to hold a fill level of 0..n
package seq_det_pkg;

  localparam int         SEQ_N       = 4;
  localparam logic [3:0] SEQ_PATTERN = 4'b1011;
  localparam int         SEQ_CNT_W   = 8;

  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk     : rising-edge clock
//   clear_n : asynchronous active-low reset, q -> 0
//   clr     : synchronous clear, wins over inc
//   inc     : add one unless already at all-ones
//   q       : counter value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_sr.sv
// rtl/seq_detector_sr.sv - sliding-window serial pattern detector with match counter
// Ports:
//   clk         : rising-edge clock
//   clear_n     : asynchronous active-low reset
//   din         : serial data bit
//   din_valid   : din is sampled this cycle
//   flush       : synchronous, discards the partial window (wins over din_valid)
//   count_clr   : synchronous, zeroes match_count (wins over an increment)
//   match       : registered one-cycle pulse when the window equals PATTERN
//   match_count : saturating number of matches
//   fill_level  : qualified bits currently in the window (0..N)
//   window      : last N qualified bits, newest in LSB
module seq_detector_sr
  import seq_det_pkg::*;
#(
  parameter int             N       = SEQ_N,
  parameter logic [N-1:0]   PATTERN = N'(SEQ_PATTERN),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = SEQ_CNT_W,
  localparam int            FW      = fill_width(N)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             flush,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [FW-1:0]    fill_level,
  output logic [N-1:0]     window
);

  logic [N-1:0]  window_nx;
  logic [FW-1:0] fill_nx;
  logic          hit;

  // fill_level gates the compare so a reset window of zeros never
  // matches an all-zero pattern before N real bits have arrived.
  always_comb begin
    window_nx = {window[N-2:0], din};
    fill_nx   = (fill_level == FW'(N)) ? fill_level : fill_level + 1'b1;
    hit       = (fill_nx == FW'(N)) && (window_nx == PATTERN);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      window     <= '0;
      fill_level <= '0;
      match      <= 1'b0;
    end else if (flush) begin
      window     <= '0;
      fill_level <= '0;
      match      <= 1'b0;
    end else if (din_valid) begin
      window <= window_nx;
      match  <= hit;
      // Non-overlapping mode keeps the bits but demands N fresh ones
      // before the next compare can succeed.
      fill_level <= (hit && !OVERLAP) ? '0 : fill_nx;
    end else begin
      match <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (count_clr),
    .inc     (din_valid && !flush && hit),
    .q       (match_count)
  );

endmodule

// File: tb/tb_seq_detector_sr.sv
// tb/tb_seq_detector_sr.sv - self-checking bench for seq_detector_sr
module tb_seq_detector_sr;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic flush = 1'b0;
  logic count_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Four instances share the stimulus: 0 default, 1 non-overlap,
  // 2 two-bit counter, 3 all-zero pattern.
  logic       mt0, mt1, mt2, mt3;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;
  logic [2:0] f0, f1, f2, f3;
  logic [3:0] w0, w1, w2, w3;

  seq_detector_sr u_ovl (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .flush(flush), .count_clr(count_clr), .match(mt0), .match_count(c0),
    .fill_level(f0), .window(w0)
  );

  seq_detector_sr #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .flush(flush), .count_clr(count_clr), .match(mt1), .match_count(c1),
    .fill_level(f1), .window(w1)
  );

  seq_detector_sr #(.CNT_W(2)) u_sat (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .flush(flush), .count_clr(count_clr), .match(mt2), .match_count(c2),
    .fill_level(f2), .window(w2)
  );

  seq_detector_sr #(.PATTERN(4'b0000)) u_zero (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .flush(flush), .count_clr(count_clr), .match(mt3), .match_count(c3),
    .fill_level(f3), .window(w3)
  );

  logic       d_match [4];
  logic [7:0] d_count [4];
  logic [2:0] d_fill  [4];
  logic [3:0] d_win   [4];

  assign d_match[0] = mt0;  assign d_match[1] = mt1;
  assign d_match[2] = mt2;  assign d_match[3] = mt3;
  assign d_count[0] = c0;   assign d_count[1] = c1;
  assign d_count[2] = {6'b0, c2};
  assign d_count[3] = c3;
  assign d_fill[0]  = f0;   assign d_fill[1]  = f1;
  assign d_fill[2]  = f2;   assign d_fill[3]  = f3;
  assign d_win[0]   = w0;   assign d_win[1]   = w1;
  assign d_win[2]   = w2;   assign d_win[3]   = w3;

  // Reference model: a queue of qualified bits since the last reset/flush,
  // plus a count of bits received since detection was last re-armed.
  int m_pat  [4] = '{11, 11, 11, 0};
  int m_ovl  [4] = '{1, 0, 1, 1};
  int m_max  [4] = '{255, 255, 3, 255};
  int hist   [4][$];
  int m_fresh[4];
  int m_count[4];
  bit m_match[4];

  function automatic int m_win(input int k);
    int v = 0;
    foreach (hist[k][i]) v = v * 2 + hist[k][i];
    return v;
  endfunction

  function automatic int m_fill(input int k);
    return (m_fresh[k] < 4) ? m_fresh[k] : 4;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      hist[k].delete();
      m_fresh[k] = 0;
      m_count[k] = 0;
      m_match[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit d, input bit v, input bit f, input bit c);
    for (int k = 0; k < 4; k++) begin
      bit hit = 1'b0;
      if (f) begin
        hist[k].delete();
        m_fresh[k] = 0;
      end else if (v) begin
        hist[k].push_back(int'(d));
        if (hist[k].size() > 4) void'(hist[k].pop_front());
        m_fresh[k]++;
        hit = (m_fresh[k] >= 4) && (m_win(k) == m_pat[k]);
        if (hit && m_ovl[k] == 0) m_fresh[k] = 0;
      end
      m_match[k] = hit;
      if (c) m_count[k] = 0;
      else if (hit && m_count[k] < m_max[k]) m_count[k]++;
    end
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit d, input bit v, input bit f, input bit c);
    din = d; din_valid = v; flush = f; count_clr = c;
    @(posedge clk);
    model_edge(d, v, f, c);
    @(negedge clk);
    din_valid = 1'b0; flush = 1'b0; count_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    bit s [3] = '{1, 0, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({d_match[k], d_count[k], d_fill[k], d_win[k]} !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state inst %0d: got %b want all zero", k,
                 {d_match[k], d_count[k], d_fill[k], d_win[k]});
      end
    end
    for (int i = 0; i < 3; i++) step(s[i], 1, 0, 0);
    n_cmp++;
    if (f0 !== 3'd3 || w0 !== 4'b0101) begin
      n_fail++;
      $display("FAIL pre_reset_fill: got fill %0d win %b want 3 0101", f0, w0);
    end
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({mt0, c0, f0, w0} !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want all zero", {mt0, c0, f0, w0});
    end
    @(negedge clk);
    clear_n = 1'b1;
    step(1, 1, 0, 0);
    n_cmp++;
    if (f0 !== 3'd1 || mt0 !== 1'b0 || f0 !== 3'(m_fill(0))) begin
      n_fail++;
      $display("FAIL post_reset_bit: got fill %0d match %0b want 1 0", f0, mt0);
    end
  endtask

  task automatic test_overlap();
    bit s [7] = '{1, 0, 1, 1, 0, 1, 1};
    bit e [7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(s[i], 1, 0, 0);
      n_cmp++;
      if (mt0 !== e[i] || mt0 !== m_match[0]) begin
        n_fail++;
        $display("FAIL overlap_match bit %0d: got %0b want %0b", i + 1, mt0, e[i]);
      end
    end
    n_cmp++;
    if (c0 !== 8'd2 || w0 !== 4'b1011) begin
      n_fail++;
      $display("FAIL overlap_end: got count %0d win %b want 2 1011", c0, w0);
    end
  endtask

  task automatic test_nonoverlap();
    bit s  [11] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    bit e  [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int fl [11] = '{1, 2, 3, 0, 1, 2, 3, 4, 4, 4, 0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(s[i], 1, 0, 0);
      n_cmp++;
      if (mt1 !== e[i] || f1 !== 3'(fl[i]) || f1 !== 3'(m_fill(1))) begin
        n_fail++;
        $display("FAIL nonoverlap bit %0d: got match %0b fill %0d want %0b %0d",
                 i + 1, mt1, f1, e[i], fl[i]);
      end
      if (i == 6) begin
        n_cmp++;
        if (c1 !== 8'd1) begin
          n_fail++;
          $display("FAIL nonoverlap_count1: got %0d want 1", c1);
        end
      end
    end
    n_cmp++;
    if (c1 !== 8'd2) begin
      n_fail++;
      $display("FAIL nonoverlap_count2: got %0d want 2", c1);
    end
  endtask

  task automatic test_gaps_flush();
    bit d [6] = '{1, 0, 0, 0, 1, 1};
    bit v [6] = '{1, 0, 0, 1, 1, 1};
    bit e [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(d[i], v[i], 0, 0);
      n_cmp++;
      if (mt0 !== e[i]) begin
        n_fail++;
        $display("FAIL gap_match cycle %0d: got %0b want %0b", i, mt0, e[i]);
      end
    end
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    n_cmp++;
    if (mt0 !== 1'b0 || f0 !== 3'd0 || w0 !== 4'd0 || c0 !== 8'd1) begin
      n_fail++;
      $display("FAIL flush: got match %0b fill %0d win %b count %0d want 0 0 0000 1",
               mt0, f0, w0, c0);
    end
  endtask

  task automatic test_saturation();
    bit p [4] = '{1, 0, 1, 1};
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) step(p[i], 1, 0, 0);
    n_cmp++;
    if (c2 !== 2'd3 || c0 !== 8'd5) begin
      n_fail++;
      $display("FAIL saturate: got cnt2 %0d cnt8 %0d want 3 5", c2, c0);
    end
    for (int i = 0; i < 3; i++) step(p[i], 1, 0, 0);
    step(1, 1, 0, 1);
    n_cmp++;
    if (mt2 !== 1'b1 || c2 !== 2'd0) begin
      n_fail++;
      $display("FAIL clr_vs_inc: got match %0b count %0d want 1 0", mt2, c2);
    end
  endtask

  task automatic test_zero_pattern();
    bit e [7] = '{0, 0, 0, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0);
      n_cmp++;
      if (mt3 !== e[i]) begin
        n_fail++;
        $display("FAIL zero_pattern bit %0d: got %0b want %0b", i + 1, mt3, e[i]);
      end
    end
    n_cmp++;
    if (c3 !== 8'd4) begin
      n_fail++;
      $display("FAIL zero_count: got %0d want 4", c3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0));
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (d_match[k] !== m_match[k] || d_count[k] !== 8'(m_count[k]) ||
            d_fill[k] !== 3'(m_fill(k)) || d_win[k] !== 4'(m_win(k))) begin
          n_fail++;
          $display("FAIL random cyc %0d inst %0d: got m%0b c%0d f%0d w%b want m%0b c%0d f%0d w%b",
                   n, k, d_match[k], d_count[k], d_fill[k], d_win[k],
                   m_match[k], m_count[k], m_fill(k), 4'(m_win(k)));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps_flush();
    test_saturation();
    test_zero_pattern();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
